// File: rtl/fracnet_mul_share_arbiter.sv
// Round-robin time-sharing of one pipelined signed multiplier between N_REQ requesters,
// with credit-limited issue and an in-order tagged first-word-fall-through result FIFO.

module fracnet_mul_share_arbiter_chk #(
   parameter int N_REQ = 4,
   parameter int OUT_DEPTH = 4,
   parameter int CW = 3
) (
   input logic             clk,
   input logic             rst,
   input logic             push,
   input logic             pop,
   input logic [CW-1:0]    count,
   input logic [N_REQ-1:0] req_valid,
   input logic [N_REQ-1:0] req_ready
);
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count == CW'(OUT_DEPTH))));
   a_fifo_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && (count == '0)));
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready) && ((req_ready & ~req_valid) == '0));
endmodule

module fracnet_mul_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_WIDTH = 2,
   parameter int A_WIDTH = 11,
   parameter int B_WIDTH = 11,
   parameter int P_WIDTH = 22,
   parameter int MUL_LATENCY = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*A_WIDTH-1:0]   req_a,
   input  logic [N_REQ*B_WIDTH-1:0]   req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_WIDTH-1:0]        rsp_id,
   output logic [P_WIDTH-1:0]         rsp_data,
   output logic                       idle
);
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int PW = $clog2(OUT_DEPTH);

   logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]             credit_q, credit_d;
   logic [CW-1:0]             count_q, count_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [MUL_LATENCY-1:0]    pv_q, pv_d;
   logic [ID_WIDTH-1:0]       ptag_q [MUL_LATENCY];
   logic [ID_WIDTH-1:0]       ptag_d [MUL_LATENCY];
   logic signed [P_WIDTH-1:0] pprod_q [MUL_LATENCY];
   logic signed [P_WIDTH-1:0] pprod_d [MUL_LATENCY];
   logic [ID_WIDTH-1:0]       fid_q [OUT_DEPTH];
   logic [ID_WIDTH-1:0]       fid_d [OUT_DEPTH];
   logic [P_WIDTH-1:0]        fdat_q [OUT_DEPTH];
   logic [P_WIDTH-1:0]        fdat_d [OUT_DEPTH];

   logic [N_REQ-1:0]          grant_s;
   logic [ID_WIDTH-1:0]       gnt_idx_s;
   logic                      found_s;
   logic signed [A_WIDTH-1:0] a_sel_s;
   logic signed [B_WIDTH-1:0] b_sel_s;
   logic signed [P_WIDTH-1:0] prod_s;
   logic                      can_issue_s, accept_s, push_s, pop_s;

   // Round-robin grant: first pass covers rr_ptr..N_REQ-1, second pass wraps to 0..rr_ptr-1.
   always_comb begin
      grant_s = '0;
      gnt_idx_s = '0;
      found_s = 1'b0;
      a_sel_s = '0;
      b_sel_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found_s && req_valid[i] && (ID_WIDTH'(i) >= rr_ptr_q)) begin
            found_s = 1'b1;
            grant_s[i] = 1'b1;
            gnt_idx_s = ID_WIDTH'(i);
            a_sel_s = req_a[i*A_WIDTH +: A_WIDTH];
            b_sel_s = req_b[i*B_WIDTH +: B_WIDTH];
         end else begin
            found_s = found_s;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found_s && req_valid[i]) begin
            found_s = 1'b1;
            grant_s[i] = 1'b1;
            gnt_idx_s = ID_WIDTH'(i);
            a_sel_s = req_a[i*A_WIDTH +: A_WIDTH];
            b_sel_s = req_b[i*B_WIDTH +: B_WIDTH];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign can_issue_s = (credit_q < CW'(OUT_DEPTH));
   assign accept_s    = can_issue_s & found_s;
   assign req_ready   = can_issue_s ? grant_s : '0;
   assign prod_s      = P_WIDTH'(a_sel_s) * P_WIDTH'(b_sel_s);
   assign push_s      = pv_q[MUL_LATENCY-1];
   assign rsp_valid   = (count_q != '0);
   assign pop_s       = rsp_valid & rsp_ready;
   assign rsp_id      = rsp_valid ? fid_q[rd_ptr_q] : '0;
   assign rsp_data    = rsp_valid ? fdat_q[rd_ptr_q] : '0;
   assign idle        = (credit_q == '0);

   // Next-state for pointer, credit, multiplier pipeline and FIFO.
   always_comb begin
      if (accept_s) begin
         rr_ptr_d = (gnt_idx_s == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_idx_s + ID_WIDTH'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      case ({accept_s, pop_s})
         2'b10:   credit_d = credit_q + CW'(1);
         2'b01:   credit_d = credit_q - CW'(1);
         default: credit_d = credit_q;
      endcase
      pv_d[0] = accept_s;
      ptag_d[0] = gnt_idx_s;
      pprod_d[0] = prod_s;
      for (int s = 1; s < MUL_LATENCY; s++) begin
         pv_d[s] = pv_q[s-1];
         ptag_d[s] = ptag_q[s-1];
         pprod_d[s] = pprod_q[s-1];
      end
      fid_d = fid_q;
      fdat_d = fdat_q;
      if (push_s) begin
         fid_d[wr_ptr_q] = ptag_q[MUL_LATENCY-1];
         fdat_d[wr_ptr_q] = pprod_q[MUL_LATENCY-1];
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset drops everything in flight or buffered.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rr_ptr_q <= '0;
         credit_q <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pv_q     <= '0;
         for (int s = 0; s < MUL_LATENCY; s++) begin
            ptag_q[s]  <= '0;
            pprod_q[s] <= '0;
         end
         for (int e = 0; e < OUT_DEPTH; e++) begin
            fid_q[e]  <= '0;
            fdat_q[e] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pv_q     <= pv_d;
         ptag_q   <= ptag_d;
         pprod_q  <= pprod_d;
         fid_q    <= fid_d;
         fdat_q   <= fdat_d;
      end
   end

   fracnet_mul_share_arbiter_chk #(
      .N_REQ(N_REQ), .OUT_DEPTH(OUT_DEPTH), .CW(CW)
   ) u_chk (
      .clk(ap_clk), .rst(ap_rst), .push(push_s), .pop(pop_s), .count(count_q),
      .req_valid(req_valid), .req_ready(req_ready)
   );
endmodule

// File: tb/tb_fracnet_mul_share_arbiter.sv
// Directed bench for fracnet_mul_share_arbiter with a cycle-level reference model and
// a scoreboard queue of expected (id, product) results.
module tb_fracnet_mul_share_arbiter;
   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [43:0] req_a;
   logic [43:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [21:0] rsp_data;
   logic        idle;

   always #5 ap_clk = ~ap_clk;

   fracnet_mul_share_arbiter dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle)
   );

   typedef struct packed {
      logic [1:0]  id;
      logic [21:0] p;
   } ent_t;

   int   n_cmp = 0;
   int   n_err = 0;
   ent_t mq[$];
   ent_t mst[3];
   logic mv[3];
   int   m_credit, m_rr, last_gnt, cyc_n;
   logic last_pop;
   int   t5_exp[4] = '{3, 1, 3, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] mulp(input logic [10:0] a, input logic [10:0] b);
      logic signed [21:0] p;
      p = 22'($signed(a)) * 22'($signed(b));
      return p;
   endfunction

   task automatic set_ops(input int i, input logic [10:0] a, input logic [10:0] b);
      req_a[i*11 +: 11] = a;
      req_b[i*11 +: 11] = b;
   endtask

   task automatic rand_ops(input int i);
      set_ops(i, 11'($urandom), 11'($urandom));
   endtask

   task automatic model_clear();
      mq.delete();
      for (int s = 0; s < 3; s++) begin
         mv[s] = 1'b0;
         mst[s] = '0;
      end
      m_credit = 0;
      m_rr = 0;
      last_gnt = -1;
      last_pop = 1'b0;
   endtask

   // One clock cycle: compare outputs at the falling edge, then advance the model.
   task automatic cyc();
      int   g;
      logic [3:0] exp_rdy;
      logic exp_rv, acc, pop;
      ent_t e;
      @(negedge ap_clk);
      exp_rv = (mq.size() != 0);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
         chk("rsp_id", rsp_id, mq[0].id);
         chk("rsp_data", rsp_data, mq[0].p);
      end
      chk("idle", idle, m_credit == 0);
      g = -1;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (m_rr + k) % 4;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = (m_credit < 4 && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("req_ready", req_ready, exp_rdy);
      acc = (exp_rdy != 4'b0000);
      pop = exp_rv && rsp_ready;
      if (pop) void'(mq.pop_front());
      if (mv[2]) mq.push_back(mst[2]);
      mv[2] = mv[1]; mst[2] = mst[1];
      mv[1] = mv[0]; mst[1] = mst[0];
      mv[0] = acc;
      if (acc) begin
         e.id = 2'(g);
         e.p = mulp(req_a[g*11 +: 11], req_b[g*11 +: 11]);
         mst[0] = e;
         m_rr = (g + 1) % 4;
      end
      m_credit += (acc ? 1 : 0) - (pop ? 1 : 0);
      last_gnt = acc ? g : -1;
      last_pop = pop;
      cyc_n++;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 4'b0000;
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      model_clear();
   endtask

   task automatic wait_rsp(input string tag);
      for (int k = 0; k < 20 && !rsp_valid; k++) cyc();
      chk({tag, "_seen"}, rsp_valid, 1'b1);
   endtask

   initial begin
      int lat, nacc, first_pop, first_acc, idx;
      ap_rst = 1'b1;
      req_valid = 4'b0000;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      cyc_n = 0;
      model_clear();
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_data", rsp_data, 22'd0);
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_idle", idle, 1'b1);

      // Single requester 0, (-1024)*(-1024).
      set_ops(0, 11'h400, 11'h400);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      cyc();
      chk("t1_accept", last_gnt, 0);
      req_valid = 4'b0000;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         if (rsp_valid) begin
            lat = k;
            break;
         end
         cyc();
      end
      chk("t1_latency", lat, 4);
      chk("t1_id", rsp_id, 2'd0);
      chk("t1_data", rsp_data, 22'h100000);
      cyc();
      chk("t1_idle_after_pop", idle, 1'b1);

      // Requester 2: 1023*(-1024), then 0*(-7), back to back.
      set_ops(2, 11'd1023, 11'h400);
      req_valid = 4'b0100;
      cyc();
      chk("t2_acc_a", last_gnt, 2);
      set_ops(2, 11'd0, 11'h7F9);
      cyc();
      chk("t2_acc_b", last_gnt, 2);
      req_valid = 4'b0000;
      wait_rsp("t2");
      chk("t2_id_a", rsp_id, 2'd2);
      chk("t2_data_a", rsp_data, 22'h300400);
      cyc();
      chk("t2_valid_b", rsp_valid, 1'b1);
      chk("t2_id_b", rsp_id, 2'd2);
      chk("t2_data_b", rsp_data, 22'h000000);
      repeat (3) cyc();

      // All four requesters streaming, consumer always ready.
      do_reset();
      for (int i = 0; i < 4; i++) rand_ops(i);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      idx = 0;
      nacc = 0;
      for (int k = 0; k < 24; k++) begin
         cyc();
         if (last_gnt >= 0) begin
            chk("t3_order", last_gnt, idx);
            idx = (idx + 1) % 4;
            nacc++;
            rand_ops(last_gnt);
         end
      end
      chk("t3_min_accepts", nacc >= 16, 1'b1);
      req_valid = 4'b0000;
      repeat (8) cyc();
      chk("t3_idle", idle, 1'b1);

      // Consumer stalled: credits run out after four accepts.
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      nacc = 0;
      repeat (8) begin
         cyc();
         if (last_gnt >= 0) begin
            nacc++;
            rand_ops(last_gnt);
         end
      end
      chk("t4_accepts", nacc, 4);
      chk("t4_ready_blocked", req_ready, 4'b0000);
      chk("t4_not_idle", idle, 1'b0);
      rsp_ready = 1'b1;
      first_pop = -1;
      first_acc = -1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (last_pop && first_pop < 0) first_pop = cyc_n;
         if (last_gnt >= 0 && first_acc < 0) first_acc = cyc_n;
         if (last_gnt >= 0) rand_ops(last_gnt);
      end
      chk("t4_resume_gap", first_acc - first_pop, 1);
      req_valid = 4'b0000;
      repeat (10) cyc();
      chk("t4_idle", idle, 1'b1);

      // Requesters 1 and 3 only, starting from rr_ptr=2.
      do_reset();
      rand_ops(1);
      rand_ops(3);
      req_valid = 4'b0010;
      cyc();
      chk("t5_prime", last_gnt, 1);
      req_valid = 4'b0000;
      repeat (6) cyc();
      req_valid = 4'b1010;
      idx = 0;
      for (int k = 0; k < 12 && idx < 4; k++) begin
         cyc();
         if (last_gnt >= 0) begin
            chk("t5_order", last_gnt, t5_exp[idx]);
            idx++;
            rand_ops(last_gnt);
         end
      end
      chk("t5_count", idx, 4);
      req_valid = 4'b0000;
      repeat (8) cyc();

      // Reset with results both in the pipeline and in the FIFO.
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      repeat (5) begin
         cyc();
         if (last_gnt >= 0) rand_ops(last_gnt);
      end
      chk("t6_pre_valid", rsp_valid, 1'b1);
      do_reset();
      chk("t6_rsp_valid", rsp_valid, 1'b0);
      chk("t6_idle", idle, 1'b1);
      rsp_ready = 1'b1;
      repeat (10) cyc();
      req_valid = 4'b1111;
      cyc();
      chk("t6_rr_zero", last_gnt, 0);
      req_valid = 4'b0000;
      repeat (8) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
